// File: rtl/sub8_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin shared 8-bit subtractor.
// Combinational only; no latency or backpressure of its own.
package sub8_rr_arbiter_pkg;

    localparam int NREQ_DEF = 4;
    localparam int OPW      = 8;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    localparam int IDW_DEF = clog2(NREQ_DEF);

endpackage

// File: rtl/sub8_rr_arbiter_borrow.sv
// 8-bit carry-chain subtractor computing A + ~B + 1; borrow is the inverted carry out.
// Purely combinational: zero latency, no backpressure.
module sub8_borrow
    import sub8_rr_arbiter_pkg::*;
(
    input  logic [OPW-1:0] i_a,
    input  logic [OPW-1:0] i_b,
    output logic [OPW-1:0] o_dat,
    output logic           o_cout
);

    logic w_c;
    logic w_p;

    // Each stage mirrors a MUXCY/XORCY pair: propagate passes carry, else generate from A.
    always_comb begin
        w_c   = 1'b1;
        w_p   = 1'b0;
        o_dat = '0;
        for (int i = 0; i < OPW; i++) begin
            w_p      = i_a[i] ^ ~i_b[i];
            o_dat[i] = w_p ^ w_c;
            w_c      = w_p ? w_c : i_a[i];
        end
        o_cout = w_c;
    end

endmodule

// File: rtl/sub8_rr_arbiter.sv
// Round-robin arbiter sharing one subtractor among NREQ requesters; result registered.
// Latency grant->o_valid 1 cycle; o_valid && !i_ready stalls grants and holds all state.
module sub8_rr_arbiter
    import sub8_rr_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NREQ-1:0]     i_req,
    input  logic [NREQ*OPW-1:0] i_a,
    input  logic [NREQ*OPW-1:0] i_b,
    output logic [NREQ-1:0]     o_gnt,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [OPW-1:0]      o_dat,
    output logic                o_borrow,
    output logic [IDW-1:0]      o_id,
    output logic [CNTW-1:0]     o_op_count
);

    logic [IDW-1:0]  r_ptr;
    logic            r_valid;
    logic [OPW-1:0]  r_dat;
    logic            r_borrow;
    logic [IDW-1:0]  r_id;
    logic [CNTW-1:0] r_cnt;

    logic [IDW-1:0]  w_sel;
    logic            w_found;
    logic [IDW:0]    w_idx;
    logic            w_accept;
    logic            w_consume;
    logic [OPW-1:0]  w_a;
    logic [OPW-1:0]  w_b;
    logic [OPW-1:0]  w_diff;
    logic            w_cout;

    // Search starts at r_ptr and wraps modulo NREQ; first requester found wins.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (!w_found && i_req[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[IDW-1:0];
            end
        end
    end

    // Reset gating keeps grants off while the output register is being cleared.
    assign w_accept  = i_rst_n && w_found && (!r_valid || i_ready);
    assign w_consume = r_valid && i_ready;
    assign o_gnt     = w_accept ? (NREQ'(1) << w_sel) : '0;

    assign w_a = i_a[{w_sel, 3'b000} +: OPW];
    assign w_b = i_b[{w_sel, 3'b000} +: OPW];

    sub8_borrow u_sub (
        .i_a    (w_a),
        .i_b    (w_b),
        .o_dat  (w_diff),
        .o_cout (w_cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr    <= '0;
            r_valid  <= 1'b0;
            r_dat    <= '0;
            r_borrow <= 1'b0;
            r_id     <= '0;
        end else if (w_accept) begin
            r_dat    <= w_diff;
            r_borrow <= ~w_cout;
            r_id     <= w_sel;
            r_valid  <= 1'b1;
            r_ptr    <= (w_sel == IDW'(NREQ-1)) ? '0 : w_sel + IDW'(1);
        end else if (w_consume) begin
            r_valid  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_consume && (r_cnt != {CNTW{1'b1}})) begin
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    assign o_valid    = r_valid;
    assign o_dat      = r_dat;
    assign o_borrow   = r_borrow;
    assign o_id       = r_id;
    assign o_op_count = r_cnt;

endmodule
